// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_pkg
// Description : Shared state encoding and default parameter values for the
//               serial pattern transmitter and its shift register.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_tx_pkg;

    // Transmitter control states
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_t;

    // Default configuration
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_CNT_W      = 4;
    localparam int DEF_GAP_CYCLES = 2;

endpackage : serial_tx_pkg
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_reg
// Description : Parallel-in serial-out shift register. Shifts left, so the
//               MSB is presented first.
// Ports       : clk         - rising-edge clock
//               reset       - synchronous active-low reset (clears register)
//               i_load      - load i_load_data (has priority over shifting)
//               i_shift_en  - shift left by one, zero filled
//               i_load_data - parallel word
//               o_msb       - current MSB of the register
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_reg
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift_en,
    input  logic [WIDTH-1:0] i_load_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (i_load) begin
            shift_d = i_load_data;
        end else if (i_shift_en) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign o_msb = shift_q[WIDTH-1];

endmodule : piso_shift_reg
`default_nettype wire

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_tx
// Description : Serial pattern transmitter. Accepts a WIDTH-bit word via a
//               start/ready handshake and sends it MSB-first on X, repeated
//               repeat_n times (0 counts as 1) with GAP_CYCLES idle cycles
//               between repetitions, then pulses done for one cycle.
// Ports       : clk       - rising-edge clock
//               reset     - synchronous active-low reset
//               data      - pattern word, captured on accepted start
//               repeat_n  - repetition count, captured on accepted start
//               start     - transfer request, accepted while ready=1
//               ready     - idle, start will be accepted
//               X         - serial data bit
//               bit_valid - X carries a pattern bit
//               busy      - sending or in an inter-repetition gap
//               done      - one-cycle pulse after the final bit
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             start,
    output logic             ready,
    output logic             X,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH) + 1;
    // A zero-cycle gap still needs a legal (unused) counter width.
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_t        state_q,    state_d;
    logic [WIDTH-1:0] hold_q,     hold_d;
    logic [CNT_W-1:0] rep_left_q, rep_left_d;
    logic [BIT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic             done_q,     done_d;

    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_load_data;
    logic             sr_msb;

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk         (clk),
        .reset       (reset),
        .i_load      (sr_load),
        .i_shift_en  (sr_shift),
        .i_load_data (sr_load_data),
        .o_msb       (sr_msb)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        rep_left_d   = rep_left_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        done_d       = 1'b0;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_load_data = hold_q;

        case (state_q)
            TX_IDLE: begin
                // Also reached in the done cycle, so back-to-back starts work.
                if (start) begin
                    hold_d       = data;
                    sr_load_data = data;
                    sr_load      = 1'b1;
                    rep_left_d   = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                    bit_cnt_d    = '0;
                    state_d      = TX_SEND;
                end
            end

            TX_SEND: begin
                sr_shift  = 1'b1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_LAST) begin
                    rep_left_d = rep_left_q - CNT_W'(1);
                    bit_cnt_d  = '0;
                    if (rep_left_q == CNT_W'(1)) begin
                        state_d = TX_IDLE;
                        done_d  = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        state_d   = TX_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        // No gap: next repetition's MSB follows immediately.
                        sr_load = 1'b1;
                    end
                end
            end

            TX_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    sr_load   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = TX_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= TX_IDLE;
            hold_q     <= '0;
            rep_left_q <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rep_left_q <= rep_left_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            done_q     <= done_d;
        end
    end

    // Outputs depend only on registered state; the shift register MSB is
    // gated so X is held low outside of pattern bits.
    assign ready     = (state_q == TX_IDLE);
    assign busy      = (state_q == TX_SEND) || (state_q == TX_GAP);
    assign bit_valid = (state_q == TX_SEND);
    assign X         = (state_q == TX_SEND) && sr_msb;
    assign done      = done_q;

endmodule : serial_pattern_tx
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pattern_tx
// Description : Testbench for serial_pattern_tx. A queue of expected
//               per-cycle output tuples is built from each accepted request
//               and compared against the design every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

    localparam int WIDTH      = 8;
    localparam int CNT_W      = 4;
    localparam int GAP_CYCLES = 2;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] repeat_n;
    logic             start;
    logic             ready;
    logic             X;
    logic             bit_valid;
    logic             busy;
    logic             done;

    serial_pattern_tx #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .repeat_n  (repeat_n),
        .start     (start),
        .ready     (ready),
        .X         (X),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle
    typedef struct packed {
        logic rdy;
        logic bsy;
        logic vld;
        logic x;
        logic dn;
    } exp_t;

    localparam exp_t EXP_IDLE = '{rdy: 1'b1, bsy: 1'b0, vld: 1'b0, x: 1'b0, dn: 1'b0};
    localparam exp_t EXP_GAP  = '{rdy: 1'b0, bsy: 1'b1, vld: 1'b0, x: 1'b0, dn: 1'b0};
    localparam exp_t EXP_DONE = '{rdy: 1'b1, bsy: 1'b0, vld: 1'b0, x: 1'b0, dn: 1'b1};

    exp_t exp_q[$];
    exp_t cur;

    int n_vec;
    int n_bad;

    task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got {rdy,bsy,vld,x,dn}=%b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a request of N repetitions is N copies of the word MSB-first,
    // GAP_CYCLES idle cycles between copies, then one done cycle.
    task automatic push_request(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] r);
        int n;
        exp_t e;
        n = (r == 0) ? 1 : int'(r);
        for (int rep = 0; rep < n; rep++) begin
            for (int b = WIDTH - 1; b >= 0; b--) begin
                e = '{rdy: 1'b0, bsy: 1'b1, vld: 1'b1, x: d[b], dn: 1'b0};
                exp_q.push_back(e);
            end
            if (rep != n - 1) begin
                for (int g = 0; g < GAP_CYCLES; g++) exp_q.push_back(EXP_GAP);
            end
        end
        exp_q.push_back(EXP_DONE);
    endtask

    // Apply one cycle of inputs, advance the reference, then check.
    task automatic step(input string tag, input logic rst_v, input logic st_v,
                        input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] r);
        bit acc;
        reset    = rst_v;
        start    = st_v;
        data     = d;
        repeat_n = r;
        @(posedge clk);
        if (!rst_v) begin
            exp_q.delete();
            cur = EXP_IDLE;
        end else begin
            acc = st_v && cur.rdy;
            if (acc) push_request(d, r);
            cur = (exp_q.size() != 0) ? exp_q.pop_front() : EXP_IDLE;
        end
        #1;
        check_val(tag, {ready, busy, bit_valid, X, done}, cur);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b1, 1'b0, WIDTH'($urandom), CNT_W'($urandom));
        end
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        cur      = EXP_IDLE;
        reset    = 1'b0;
        start    = 1'b0;
        data     = '0;
        repeat_n = '0;

        // Reset state
        step("reset", 1'b0, 1'b1, 8'hFF, 4'd3);

        // Single transmission of A5
        step("single", 1'b1, 1'b1, 8'hA5, 4'd1);
        idle_steps("single", 10);

        // Two repetitions with gap
        step("gap", 1'b1, 1'b1, 8'hC3, 4'd2);
        idle_steps("gap", 20);

        // repeat_n = 0 behaves as 1
        step("zero", 1'b1, 1'b1, 8'hFF, 4'd0);
        idle_steps("zero", 10);

        // Start while busy is ignored
        step("busy", 1'b1, 1'b1, 8'hA5, 4'd1);
        idle_steps("busy", 3);
        step("busy", 1'b1, 1'b1, 8'h00, 4'd3);
        idle_steps("busy", 10);

        // Reset mid-transfer: no done afterwards
        step("abort", 1'b1, 1'b1, 8'h5A, 4'd2);
        idle_steps("abort", 2);
        step("abort", 1'b0, 1'b0, 8'h5A, 4'd2);
        idle_steps("abort", 12);

        // Back-to-back: new start in the done cycle
        step("b2b", 1'b1, 1'b1, 8'h3C, 4'd1);
        for (int i = 0; i < 40 && !cur.dn; i++) idle_steps("b2b", 1);
        if (!cur.dn) begin
            n_vec++;
            n_bad++;
            $display("FAIL b2b_timeout: done never expected within budget");
        end
        step("b2b", 1'b1, 1'b1, 8'h81, 4'd1);
        n_vec++;
        if (X !== 1'b1 || bit_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_msb: got X=%b bit_valid=%b expected 1 1", X, bit_valid);
        end
        idle_steps("b2b", 10);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step("rand", ($urandom_range(0, 79) != 0), ($urandom_range(0, 3) == 0),
                 WIDTH'($urandom), CNT_W'($urandom_range(0, 3)));
        end
        idle_steps("drain", 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_serial_pattern_tx
`default_nettype wire
